// File: rtl/core_if_q.sv
// core_if_q -- instruction-fetch stage with a decoupled fetch queue.
//
// Issues sequential PC requests to the L1I over a valid/ready handshake.
// Requests in flight are credit-limited so that every response is
// guaranteed a free slot in the fetch queue. Responses arrive in request
// order and are buffered in a FIFO that feeds decode. A redirect clears
// the FIFO, reloads the PC, and marks every request still in flight as
// stale so its response is dropped when it arrives.
//
// Optional feature macro: CORE_IF_MISALIGN_EN
//   defined   : a redirect target with addr[1:0] != 0 becomes a single
//               faulting queue entry (instr = NOP 0x13, err = 1); fetch halts.
//   undefined : redirect target bits [1:0] are forced to zero.
//
// Ports
//   clk, n_rst                 clock, synchronous active-low reset
//   if_stop_in                 hazard stop: blocks new requests only
//   if_redirect_in/_addr_in    redirect (highest priority) and its target
//   l1i_req_*                  request channel (val/rdy/addr)
//   l1i_rsp_*                  in-order response channel (val/data/err)
//   dec_*                      queue head towards decode (val/rdy/pc/pc+4/instr/err)
module core_if_q #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_START = 32'h0000_0200,
  parameter int unsigned       FQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              if_stop_in,
  input  logic              if_redirect_in,
  input  logic [ADDR_W-1:0] if_redirect_addr_in,
  output logic              l1i_req_val_out,
  input  logic              l1i_req_rdy_in,
  output logic [ADDR_W-1:0] l1i_req_addr_out,
  input  logic              l1i_rsp_val_in,
  input  logic [31:0]       l1i_rsp_data_in,
  input  logic              l1i_rsp_err_in,
  output logic              dec_val_out,
  input  logic              dec_rdy_in,
  output logic [ADDR_W-1:0] dec_pc_out,
  output logic [ADDR_W-1:0] dec_pc_4_out,
  output logic [31:0]       dec_instr_out,
  output logic              dec_err_out
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FQ_DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, MISAL = 2'd1, HALT = 2'd2} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic              err;
  } fq_ent_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;   // PC of the next non-dropped response
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  fq_ent_t           fq_mem_q [FQ_DEPTH];

  logic [ADDR_W-1:0] tgt;
  logic              req_fire, rsp_v, pop, push;
  fq_ent_t           push_ent, head;
  logic [CNT_W:0]    credit_use;

`ifdef CORE_IF_MISALIGN_EN
  logic tgt_misal;
  assign tgt       = if_redirect_addr_in;
  assign tgt_misal = |if_redirect_addr_in[1:0];
`else
  logic [1:0] unused_addr_lo;
  assign unused_addr_lo = if_redirect_addr_in[1:0];
  assign tgt            = {if_redirect_addr_in[ADDR_W-1:2], 2'b00};
`endif

  // Requests in flight plus queued entries never exceed the queue depth,
  // so a response can always be pushed.
  assign credit_use      = {1'b0, outst_q} + {1'b0, cnt_q};
  assign l1i_req_val_out = (state_q == RUN) & ~if_stop_in & ~if_redirect_in &
                           (credit_use < DEPTH_C);
  assign l1i_req_addr_out = pc_q;
  assign req_fire         = l1i_req_val_out & l1i_req_rdy_in;
  assign rsp_v            = l1i_rsp_val_in & (outst_q != '0);

  assign dec_val_out = (cnt_q != '0);
  assign pop         = dec_val_out & dec_rdy_in & ~if_redirect_in;
  assign head        = fq_mem_q[rd_q];

  // Head fields are gated so stale storage is never visible.
  assign dec_pc_out    = dec_val_out ? head.pc : '0;
  assign dec_pc_4_out  = dec_val_out ? head.pc + ADDR_W'(4) : '0;
  assign dec_instr_out = dec_val_out ? head.instr : '0;
  assign dec_err_out   = dec_val_out & head.err;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    outst_d  = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_v);
    push     = 1'b0;
    push_ent = '{pc: rsp_pc_q, instr: l1i_rsp_data_in, err: l1i_rsp_err_in};
    if (if_redirect_in) begin
      // Everything still in flight, minus a response landing now, is stale.
      cnt_d    = '0;
      rd_d     = '0;
      wr_d     = '0;
      pc_d     = tgt;
      rsp_pc_d = tgt;
      drop_d   = outst_q - CNT_W'(rsp_v);
      state_d  = RUN;
`ifdef CORE_IF_MISALIGN_EN
      if (tgt_misal) state_d = MISAL;
`endif
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_W'(4);
      if (rsp_v) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + ADDR_W'(4);
          if (l1i_rsp_err_in) state_d = HALT;
        end
      end
`ifdef CORE_IF_MISALIGN_EN
      // No request was issued from MISAL and all older responses are being
      // dropped, so this synthetic fault entry is the only push this cycle.
      if (state_q == MISAL) begin
        push     = 1'b1;
        push_ent = '{pc: pc_q, instr: 32'h0000_0013, err: 1'b1};
        state_d  = HALT;
      end
`endif
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= RUN;
      pc_q     <= PC_START;
      rsp_pc_q <= PC_START;
      outst_q  <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // Queue storage needs no reset: reads are gated by the entry count.
  always_ff @(posedge clk) begin
    if (push) fq_mem_q[wr_q] <= push_ent;
  end

endmodule

// File: tb/tb_core_if_q.sv
// Bench for core_if_q. A transaction-level L1I model answers accepted
// requests in order after a configurable latency; each request is tagged
// with the redirect epoch it was issued in. The reference model predicts
// the decode stream as a queue of {pc, instr, err} and checks the request
// channel against the issue rules every cycle.
module tb_core_if_q;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        if_stop_in, if_redirect_in;
  logic [31:0] if_redirect_addr_in;
  logic        l1i_req_val_out, l1i_req_rdy_in;
  logic [31:0] l1i_req_addr_out;
  logic        l1i_rsp_val_in, l1i_rsp_err_in;
  logic [31:0] l1i_rsp_data_in;
  logic        dec_val_out, dec_rdy_in, dec_err_out;
  logic [31:0] dec_pc_out, dec_pc_4_out, dec_instr_out;

  always #5 clk = ~clk;

  core_if_q #(.ADDR_W(32), .PC_START(32'h0000_0200), .FQ_DEPTH(D)) dut (
    .clk(clk), .n_rst(n_rst),
    .if_stop_in(if_stop_in), .if_redirect_in(if_redirect_in),
    .if_redirect_addr_in(if_redirect_addr_in),
    .l1i_req_val_out(l1i_req_val_out), .l1i_req_rdy_in(l1i_req_rdy_in),
    .l1i_req_addr_out(l1i_req_addr_out),
    .l1i_rsp_val_in(l1i_rsp_val_in), .l1i_rsp_data_in(l1i_rsp_data_in),
    .l1i_rsp_err_in(l1i_rsp_err_in),
    .dec_val_out(dec_val_out), .dec_rdy_in(dec_rdy_in),
    .dec_pc_out(dec_pc_out), .dec_pc_4_out(dec_pc_4_out),
    .dec_instr_out(dec_instr_out), .dec_err_out(dec_err_out)
  );

  typedef struct { logic [31:0] addr; int ep; int t; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } ent_t;

  req_t        pend[$];
  ent_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0, epoch = 0;
  logic [31:0] next_pc = 32'h0000_0200;
  bit          halted = 0, misal_pend = 0;
  logic [31:0] misal_pc = '0;
  int          p_rdy = 100, p_drdy = 100, p_stop = 0, p_rsp = 100, lat = 2;
  logic [31:0] err_addr = 32'hFFFF_FFFF;   // unaligned: never matches a request
  int          n_fire = 0, n_pop = 0;
  logic [31:0] last_pop_pc = '0, err_pop_pc = '0, wrap_pc4 = 32'hDEAD_BEEF;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check at negedge+1, update model.
  task automatic step(input bit redir, input logic [31:0] tgt);
    bit rsp, fire, pop, ev;
    req_t r;
    logic [31:0] p4;
    l1i_req_rdy_in      = ($urandom_range(99) < p_rdy);
    dec_rdy_in          = ($urandom_range(99) < p_drdy);
    if_stop_in          = ($urandom_range(99) < p_stop);
    if_redirect_in      = redir;
    if_redirect_addr_in = tgt;
    rsp = (pend.size() != 0) && (pend[0].t + lat <= cyc) && ($urandom_range(99) < p_rsp);
    l1i_rsp_val_in  = rsp;
    l1i_rsp_data_in = rsp ? instr_of(pend[0].addr) : $urandom;
    l1i_rsp_err_in  = rsp ? (pend[0].addr == err_addr) : 1'($urandom_range(1));
    #1;
    ev = !halted && !if_stop_in && !redir && (pend.size() + sb.size() < D);
    chk("req_val", l1i_req_val_out, ev);
    if (ev) chk("req_addr", l1i_req_addr_out, next_pc);
    chk("dec_val", dec_val_out, sb.size() != 0);
    if (dec_val_out && sb.size() != 0) begin
      p4 = sb[0].pc + 32'd4;
      chk("dec_pc", dec_pc_out, sb[0].pc);
      chk("dec_pc_4", dec_pc_4_out, p4);
      chk("dec_instr", dec_instr_out, sb[0].instr);
      chk("dec_err", dec_err_out, sb[0].err);
      if (dec_pc_out == 32'hFFFF_FFFC) wrap_pc4 = dec_pc_4_out;
    end
    fire = l1i_req_val_out && l1i_req_rdy_in;
    pop  = dec_val_out && dec_rdy_in && !redir && sb.size() != 0;
    if (pop) begin
      last_pop_pc = dec_pc_out;
      if (dec_err_out) err_pop_pc = dec_pc_out;
      void'(sb.pop_front());
      n_pop++;
    end
    if (rsp) begin
      r = pend.pop_front();
      if (!redir && r.ep == epoch) begin
        sb.push_back('{r.addr, instr_of(r.addr), r.addr == err_addr});
        if (r.addr == err_addr) halted = 1;
      end
    end
`ifdef CORE_IF_MISALIGN_EN
    if (misal_pend && !redir) begin
      sb.push_back('{misal_pc, 32'h0000_0013, 1'b1});
      misal_pend = 0;
    end
`endif
    if (fire) begin
      pend.push_back('{l1i_req_addr_out, epoch, cyc});
      next_pc += 32'd4;
      n_fire++;
    end
    if (redir) begin
      sb.delete();
      epoch++;
      halted     = 0;
      misal_pend = 0;
      next_pc    = {tgt[31:2], 2'b00};
`ifdef CORE_IF_MISALIGN_EN
      if (tgt[1:0] != 2'b00) begin
        halted = 1; misal_pend = 1; misal_pc = tgt;
      end
`endif
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  initial begin
    bit          rd;
    logic [31:0] t;
    n_rst = 1'b0;
    if_stop_in = 0; if_redirect_in = 0; if_redirect_addr_in = '0;
    l1i_req_rdy_in = 0; l1i_rsp_val_in = 0; l1i_rsp_data_in = '0;
    l1i_rsp_err_in = 0; dec_rdy_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_val", dec_val_out, 1'b0);
    chk("rst_dec_pc", dec_pc_out, 32'h0);
    chk("rst_dec_pc_4", dec_pc_4_out, 32'h0);
    chk("rst_dec_instr", dec_instr_out, 32'h0);
    chk("rst_dec_err", dec_err_out, 1'b0);
    chk("rst_req_addr", l1i_req_addr_out, 32'h0000_0200);
    n_rst = 1'b1;

    // Fill: decode stalled, queue depth worth of requests, then stop.
    p_drdy = 0; n_fire = 0;
    run(12);
    chk("fill_fires", n_fire, D);
    chk("fill_head_val", dec_val_out, 1'b1);
    chk("fill_head_pc", dec_pc_out, 32'h0000_0200);
    p_drdy = 100; n_pop = 0;
    run(4);
    chk("drain_pops", n_pop, D);

    // Sustained throughput with 2-cycle latency.
    step(1'b1, 32'h0000_0200);
    run(10);
    n_pop = 0;
    run(30);
    chk("throughput", n_pop, 30);

    // Redirect with requests in flight.
    lat = 3;
    run(8);
    step(1'b1, 32'h0000_1000);
    n_pop = 0;
    for (int i = 0; i < 50 && n_pop == 0; i++) step(1'b0, 32'h0);
    chk("redir_popped", n_pop > 0, 1'b1);
    chk("redir_first_pc", last_pop_pc, 32'h0000_1000);

    // Fetch fault at 0x208 halts issue until redirect.
    lat = 2; err_addr = 32'h0000_0208; err_pop_pc = '0;
    step(1'b1, 32'h0000_0200);
    run(30);
    chk("err_pc", err_pop_pc, 32'h0000_0208);
    chk("halt_no_req", l1i_req_val_out, 1'b0);
    err_addr = 32'hFFFF_FFFF;
    step(1'b1, 32'h0000_0300);
    if_redirect_in = 0; if_stop_in = 0; #1;
    chk("restart_val", l1i_req_val_out, 1'b1);
    chk("restart_addr", l1i_req_addr_out, 32'h0000_0300);
    run(10);

    // Misaligned redirect target.
    step(1'b1, 32'h0000_0402);
    if_redirect_in = 0; if_stop_in = 0; #1;
`ifdef CORE_IF_MISALIGN_EN
    chk("misal_no_req", l1i_req_val_out, 1'b0);
    p_drdy = 0;
    step(1'b0, 32'h0);
    chk("misal_pc", dec_pc_out, 32'h0000_0402);
    chk("misal_instr", dec_instr_out, 32'h0000_0013);
    chk("misal_err", dec_err_out, 1'b1);
    p_drdy = 100;
    run(5);
    chk("misal_idle", l1i_req_val_out, 1'b0);
`else
    chk("misal_addr", l1i_req_addr_out, 32'h0000_0400);
    run(10);
`endif

    // Address wrap at the top of the space.
    step(1'b1, 32'hFFFF_FFF8);
    run(12);
    chk("wrap_pc4", wrap_pc4, 32'h0);

    // Randomized traffic with random redirects and faults.
    for (int ph = 0; ph < 3; ph++) begin
      p_rdy  = 40 + 30 * ph;
      p_drdy = 90 - 25 * ph;
      p_stop = 10 + 5 * ph;
      p_rsp  = 50 + 20 * ph;
      lat    = 1 + ph;
      for (int i = 0; i < 400; i++) begin
        rd = ($urandom_range(99) < 3);
        t  = $urandom;
        if (rd) err_addr = ($urandom_range(1) != 0) ?
                           ({t[31:2], 2'b00} + 32'(4 * $urandom_range(0, 8))) : 32'hFFFF_FFFF;
        step(rd, t);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
